keypad_sequencer: RTL

KEYPAD_SEQUENCER -- requirements
Module: keypad_sequencer

---
 rtl/keypad_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/keypad_sequencer.sv
// Keypad entry sequencer: collects BCD digits into a downstream digit buffer and
// issues commit / compare / clear strobes for a password-entry front end.
module keypad_sequencer #(
   parameter int MAX_DIGITS = 6,
   parameter int MIN_DIGITS = 4,
   parameter int TIMEOUT    = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   input  logic                  set_mode,
   output logic [3:0]            data,
   output logic [MAX_DIGITS-1:0] cs,
   output logic                  wr,
   output logic                  compare,
   output logic                  clear,
   output logic [2:0]            digit_count,
   output logic                  overflow,
   output logic                  busy
);

   localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [2:0]      MAX_C   = 3'(MAX_DIGITS);
   localparam logic [2:0]      MIN_C   = 3'(MIN_DIGITS);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTRY   = 3'd1,
      WRITE   = 3'd2,
      COMMIT  = 3'd3,
      COMPARE = 3'd4,
      CLEAR   = 3'd5
   } state_t;

   state_t                  state_r, next_state_s;
   logic [CNT_W-1:0]        idle_cnt_r, idle_next_s;
   logic [2:0]              count_r, count_next_s;
   logic [3:0]              data_r, data_next_s;
   logic                    ovf_next_s;
   logic                    accept_s;
   logic [MAX_DIGITS-1:0]   cs_r, cs_next_s;
   logic                    wr_r, compare_r, clear_r, overflow_r, busy_r;

   function automatic logic [MAX_DIGITS-1:0] one_hot(input logic [2:0] idx);
      logic [MAX_DIGITS-1:0] base;
      base = {{(MAX_DIGITS-1){1'b0}}, 1'b1};
      return base << idx;
   endfunction

   // Keys are only taken in IDLE/ENTRY; illegal codes never count as accepted.
   assign accept_s = key_valid && ((state_r == IDLE) || (state_r == ENTRY)) && (key_code <= 4'hB);

   // Next-state, digit count, data latch and idle-timeout logic.
   always_comb begin
      next_state_s = state_r;
      count_next_s = count_r;
      data_next_s  = data_r;
      ovf_next_s   = 1'b0;
      idle_next_s  = {CNT_W{1'b0}};
      case (state_r)
         IDLE, ENTRY: begin
            if (accept_s) begin
               if (key_code <= 4'h9) begin
                  if (count_r < MAX_C) begin
                     next_state_s = WRITE;
                     data_next_s  = key_code;
                  end else begin
                     ovf_next_s = 1'b1;
                  end
               end else if (key_code == 4'hA) begin
                  if (count_r >= MIN_C) begin
                     if (set_mode) begin
                        next_state_s = COMMIT;
                     end else begin
                        next_state_s = COMPARE;
                     end
                  end else begin
                     next_state_s = CLEAR;
                  end
               end else begin
                  next_state_s = CLEAR;
               end
            end else if (state_r == ENTRY) begin
               // Timeout lands on the TIMEOUT-th edge spent in ENTRY.
               if (idle_cnt_r == TO_LAST) begin
                  next_state_s = CLEAR;
               end else begin
                  idle_next_s = idle_cnt_r + CNT_ONE;
               end
            end else begin
               idle_next_s = {CNT_W{1'b0}};
            end
         end
         WRITE: begin
            next_state_s = ENTRY;
            count_next_s = count_r + 3'd1;
         end
         COMMIT, COMPARE: begin
            next_state_s = CLEAR;
         end
         CLEAR: begin
            next_state_s = IDLE;
            count_next_s = 3'd0;
         end
         default: begin
            next_state_s = IDLE;
            count_next_s = 3'd0;
         end
      endcase
   end

   // Output decode from the upcoming state so every strobe comes straight off a flop.
   always_comb begin
      cs_next_s = {MAX_DIGITS{1'b0}};
      case (next_state_s)
         WRITE:   cs_next_s = one_hot(count_r);
         COMMIT:  cs_next_s = {MAX_DIGITS{1'b1}};
         default: cs_next_s = {MAX_DIGITS{1'b0}};
      endcase
   end

   // State, datapath and registered output flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         idle_cnt_r <= {CNT_W{1'b0}};
         count_r    <= 3'd0;
         data_r     <= 4'd0;
         cs_r       <= {MAX_DIGITS{1'b0}};
         wr_r       <= 1'b0;
         compare_r  <= 1'b0;
         clear_r    <= 1'b0;
         overflow_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         idle_cnt_r <= idle_next_s;
         count_r    <= count_next_s;
         data_r     <= data_next_s;
         cs_r       <= cs_next_s;
         wr_r       <= (next_state_s == COMMIT);
         compare_r  <= (next_state_s == COMPARE);
         clear_r    <= (next_state_s == CLEAR);
         overflow_r <= ovf_next_s;
         busy_r     <= (next_state_s != IDLE) && (next_state_s != ENTRY);
      end
   end

   assign data        = data_r;
   assign cs          = cs_r;
   assign wr          = wr_r;
   assign compare     = compare_r;
   assign clear       = clear_r;
   assign digit_count = count_r;
   assign overflow    = overflow_r;
   assign busy        = busy_r;

endmodule
